shift_left_right: RTL and testbench
===================================

Name: shift_left_right

Overview:
Parameterised logical barrel shifter with registered output. It shifts a WIDTH-bit operand left or right by 0..WIDTH-1 positions, selected per transaction. Results are registered once, with a companion valid flag. It is a datapath utility used wherever a variable shift is needed, such as ALU shift ops and field alignment.

Parameters:
WIDTH, 4, operand and result width in bits; legal range is 2 or more.
NUM_W, $clog2(WIDTH), width of the shift-amount port; derived, do not override.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  qualifies in/dir/num this cycle
in  input  WIDTH  operand
dir  input  1  0 = shift left (toward MSB), 1 = shift right (toward LSB)
num  input  NUM_W  shift amount, 0..2^NUM_W-1
out  output  WIDTH  registered shift result
out_valid  output  1  out holds the result of a transaction accepted on the previous edge

Interface: one clock; reset is asynchronous and active-high.

Behaviour:
- Reset:
  - rst high clears out to 0 and out_valid to 0 immediately, without waiting for a clock edge.
  - Both stay 0 while rst is held.
- Operation:
  - Computed combinationally, then registered. Latency is 1 cycle. Throughput is 1 per cycle.
  - dir=0: out <= in << num. Vacated LSBs are filled with 0.
  - dir=1: out <= in >> num. This is a logical shift; vacated MSBs are filled with 0.
  - There is no rotate and no sign extension.
- Shift amount:
  - num=0 passes the operand through unchanged.
  - num >= WIDTH is only reachable when WIDTH is not a power of 2. In that case out <= 0 for either direction.
- Valid flag:
  - On each rising edge with in_valid=1: out is updated and out_valid <= 1.
  - On each rising edge with in_valid=0: out holds its previous value and out_valid <= 0.
  - Back-to-back valid cycles each produce a result on the following cycle, with no bubbles.
- Reset mid-stream:
  - Any in-flight result is discarded and out is 0.
  - The first valid input after rst deasserts yields out_valid one edge later.
- Implementation:
  - Log-stage barrel structure with NUM_W stages. Stage k shifts by 2^k when num[k]=1.
  - The direction mux is applied per stage. Alternatively, reverse the bits, shift left, and reverse back.
  - No latches. All state is in one always block with async reset.

Decomposition:
- No shared package types are needed.
- Shared package holds the direction encodings: DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1.
- One natural sub-module: shift_stage. It is a combinational single-stage conditional shift by a fixed power of two, parameterised by WIDTH and AMOUNT, with inputs en and dir. The top instantiates NUM_W of these in a generate loop, followed by the output register.

Test Plan:
1. Reset: assert rst asynchronously between edges -> out=4'b0000 and out_valid=0 immediately; no edge is required.
2. in=4'b1011, dir=0, num=3, in_valid=1 -> after one edge, out=4'b1000, out_valid=1.
3. in=4'b1011, dir=1, num=3 on the next cycle (back-to-back) -> out=4'b0001, out_valid=1 one edge later.
4. in=4'b1011, num=0 for both dir values -> out=4'b1011. Then dir=0, num=1 -> 4'b0110; dir=1, num=1 -> 4'b0101.
5. in_valid=0 for 2 cycles with changing in/num -> out holds its last value and out_valid=0.
6. WIDTH=5: in=5'b10111, num=5..7, both dirs -> out=0. Also num=2, dir=1 -> 5'b00101; assert rst mid-stream -> out=0, out_valid=0.

Source files
------------

// File: rtl/shift_left_right_pkg.sv
// Shared encodings for the shift_left_right barrel shifter.
// Holds the direction encoding used on the dir port and inside each shift stage.
// No types or state; constants only.
package shift_left_right_pkg;

    localparam logic DIR_LEFT  = 1'b0;  // toward MSB, zero-fill LSBs
    localparam logic DIR_RIGHT = 1'b1;  // toward LSB, zero-fill MSBs (logical)

endpackage : shift_left_right_pkg

// File: rtl/shift_left_right_shift_stage.sv
// Purpose: one combinational barrel stage, a conditional logical shift by a fixed AMOUNT.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the output follows the inputs.
// Ports: en enables the shift (otherwise pass-through), dir picks left/right,
//        din is the stage input, dout is the stage output.
module shift_stage
    import shift_left_right_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int AMOUNT = 1
) (
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = din;
        if (en) begin
            if (dir == DIR_LEFT) begin
                dout = din << AMOUNT;
            end else begin
                dout = din >> AMOUNT;
            end
        end
    end

endmodule : shift_stage

// File: rtl/shift_left_right.sv
// Purpose: logical barrel shifter (left/right by 0..WIDTH-1) with a registered result and valid flag.
// Latency: 1 cycle, throughput 1 per cycle; out holds when in_valid is low.
// Backpressure: none; every in_valid cycle yields out_valid on the following edge.
// Ports: clk, rst (async active-high), in_valid/in/dir/num request, out/out_valid registered result.
module shift_left_right #(
    parameter int WIDTH = 4,
    parameter int NUM_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic             dir,
    input  logic [NUM_W-1:0] num,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    // stage_dat[0] is the operand; stage_dat[NUM_W] is the fully shifted value.
    logic [WIDTH-1:0] stage_dat [NUM_W+1];

    logic [WIDTH-1:0] out_d, out_q;
    logic             out_valid_d, out_valid_q;

    assign stage_dat[0] = in;

    // Stage k shifts by 2^k. Each stage amount is below WIDTH, and when the
    // summed shift reaches WIDTH or more (non-power-of-two WIDTH) every bit has
    // been pushed out, so the zero result falls out without extra clamping.
    for (genvar k = 0; k < NUM_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH  (WIDTH),
            .AMOUNT (1 << k)
        ) u_stage (
            .en   (num[k]),
            .dir  (dir),
            .din  (stage_dat[k]),
            .dout (stage_dat[k+1])
        );
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            out_d       = stage_dat[NUM_W];
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule : shift_left_right

// File: tb/tb_shift_left_right.sv
// Bench for shift_left_right: a WIDTH=4 and a WIDTH=5 instance driven in lockstep,
// directed steps followed by random traffic, compared against an arithmetic shift model.
module tb_shift_left_right;

    logic       clk = 1'b0;
    logic       rst;

    logic       v4, d4, ov4;
    logic [3:0] in4, out4;
    logic [1:0] n4;

    logic       v5, d5, ov5;
    logic [4:0] in5, out5;
    logic [2:0] n5;

    logic [31:0] exp4, exp5;
    logic        ev4, ev5;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_left_right #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in(in4), .dir(d4), .num(n4),
        .out(out4), .out_valid(ov4)
    );

    shift_left_right #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in(in5), .dir(d5), .num(n5),
        .out(out5), .out_valid(ov5)
    );

    // Shift expressed as multiply/divide by a power of two, truncated to w bits.
    function automatic logic [31:0] model_shift(input int w, input logic [31:0] a,
                                                input logic d, input int n);
        longint unsigned p, m, r;
        if (n >= w) return 32'd0;
        p = 64'd1 << n;
        m = 64'd1 << w;
        if (d == 1'b0) r = (64'(a) * p) % m;
        else           r = 64'(a) / p;
        return r[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " out4"}, {28'd0, out4}, exp4);
        chk({tag, " vld4"}, {31'd0, ov4},  {31'd0, ev4});
        chk({tag, " out5"}, {27'd0, out5}, exp5);
        chk({tag, " vld5"}, {31'd0, ov5},  {31'd0, ev5});
    endtask

    // Apply one cycle of inputs to both instances, clock once, update model, check.
    task automatic drive(input string tag,
                         input logic a_v, input logic [3:0] a_i, input logic a_d, input logic [1:0] a_n,
                         input logic b_v, input logic [4:0] b_i, input logic b_d, input logic [2:0] b_n);
        v4 = a_v; in4 = a_i; d4 = a_d; n4 = a_n;
        v5 = b_v; in5 = b_i; d5 = b_d; n5 = b_n;
        @(posedge clk);
        #1;
        if (a_v) begin exp4 = model_shift(4, {28'd0, a_i}, a_d, int'(a_n)); ev4 = 1'b1; end
        else     ev4 = 1'b0;
        if (b_v) begin exp5 = model_shift(5, {27'd0, b_i}, b_d, int'(b_n)); ev5 = 1'b1; end
        else     ev5 = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst = 1'b1;
        v4 = 0; in4 = 0; d4 = 0; n4 = 0;
        v5 = 0; in5 = 0; d5 = 0; n5 = 0;
        exp4 = 0; exp5 = 0; ev4 = 0; ev5 = 0;

        // Reset state while held.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        // Left by 3, then right by 3 back-to-back.
        drive("l3", 1, 4'b1011, 0, 2'd3, 1, 5'b10111, 0, 3'd1);
        chk("l3 lit", {28'd0, out4}, 32'b1000);
        drive("r3", 1, 4'b1011, 1, 2'd3, 1, 5'b10111, 1, 3'd1);
        chk("r3 lit", {28'd0, out4}, 32'b0001);
        chk("r3 vld lit", {31'd0, ov4}, 32'd1);

        // Zero shift passes through; shifts by one.
        drive("l0", 1, 4'b1011, 0, 2'd0, 1, 5'b10111, 0, 3'd0);
        chk("l0 lit", {28'd0, out4}, 32'b1011);
        drive("r0", 1, 4'b1011, 1, 2'd0, 1, 5'b10111, 1, 3'd0);
        chk("r0 lit", {28'd0, out4}, 32'b1011);
        drive("l1", 1, 4'b1011, 0, 2'd1, 1, 5'b10111, 0, 3'd4);
        chk("l1 lit", {28'd0, out4}, 32'b0110);
        drive("r1", 1, 4'b1011, 1, 2'd1, 1, 5'b10111, 1, 3'd4);
        chk("r1 lit", {28'd0, out4}, 32'b0101);

        // Idle cycles with changing inputs: out holds, valid drops.
        drive("idle1", 0, 4'b0110, 0, 2'd2, 0, 5'b01010, 0, 3'd3);
        chk("idle1 hold lit", {28'd0, out4}, 32'b0101);
        drive("idle2", 0, 4'b1111, 1, 2'd1, 0, 5'b11111, 1, 3'd2);
        chk("idle2 hold lit", {28'd0, out4}, 32'b0101);

        // WIDTH=5 out-of-range shift amounts clear the result in both directions.
        for (int n = 5; n <= 7; n++) begin
            drive($sformatf("w5 l%0d", n), 1, 4'b1001, 0, 2'd2, 1, 5'b10111, 0, 3'(n));
            chk($sformatf("w5 l%0d lit", n), {27'd0, out5}, 32'd0);
            drive($sformatf("w5 r%0d", n), 1, 4'b1001, 1, 2'd2, 1, 5'b10111, 1, 3'(n));
            chk($sformatf("w5 r%0d lit", n), {27'd0, out5}, 32'd0);
        end
        drive("w5 r2", 1, 4'b1001, 1, 2'd2, 1, 5'b10111, 1, 3'd2);
        chk("w5 r2 lit", {27'd0, out5}, 32'b00101);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive($sformatf("rnd%0d", i),
                  1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom), 2'($urandom),
                  1'($urandom_range(0, 3) != 0), 5'($urandom), 1'($urandom), 3'($urandom));
        end

        // Mid-stream asynchronous reset: clears between edges, holds while asserted.
        drive("pre rst", 1, 4'b0111, 0, 2'd1, 1, 5'b01101, 0, 3'd1);
        #3 rst = 1'b1;
        #1;
        exp4 = 0; exp5 = 0; ev4 = 0; ev5 = 0;
        check_all("async rst");
        v4 = 1; in4 = 4'b1111; v5 = 1; in5 = 5'b11111;
        @(posedge clk);
        #1;
        check_all("rst held");
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        drive("post rst", 1, 4'b0011, 0, 2'd2, 1, 5'b00011, 0, 3'd3);
        chk("post rst lit", {28'd0, out4}, 32'b1100);
        drive("post rst idle", 0, 4'b0000, 0, 2'd0, 0, 5'b00000, 0, 3'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_shift_left_right
